// File: rtl/hd_pkg.sv
// Shared Hamming codeword helpers: placement map and syndrome, so encoder-side
// and decoder-side blocks agree on the {parity, data} packing.
package hd_pkg;

  localparam int K_DEF  = 11;
  localparam int M_DEF  = 4;
  localparam int CW_W   = K_DEF + M_DEF;
  localparam int SYN_W  = M_DEF;
  localparam int MAX_CW = 64;
  localparam int MAX_M  = 8;

  // Position j (0-based) carries parity bit log2(j+1) when j+1 is a power of two.
  function automatic bit is_parity_pos(input int j);
    return ((j + 1) & j) == 0;
  endfunction

  function automatic logic [MAX_M-1:0] syndrome(input logic [MAX_CW-1:0] placed,
                                                input int cw_w);
    logic [MAX_M-1:0] s;
    s = '0;
    for (int j = 0; j < MAX_CW; j++) begin
      if (j < cw_w) begin
        for (int i = 0; i < MAX_M; i++) begin
          if ((((j + 1) >> i) & 1) != 0) s[i] = s[i] ^ placed[j];
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hd_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority over inc.
module hd_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hd_syn_dec.sv
// Two-stage Hamming SEC decoder: stage 1 registers the syndrome, stage 2 corrects.
// Error statistics counters are built only when HD_SYN_DEC_ERR_CNT_EN is defined.
module hd_syn_dec
  import hd_pkg::*;
#(
  parameter int K     = 11,
  parameter int M     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [K+M-1:0]   cin,
  input  logic             cvld,
  output logic [K-1:0]     dout,
  output logic             dvld,
  output logic             corr,
  output logic             uncorr,
  output logic [M-1:0]     err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam int          CW     = K + M;
  localparam logic [M-1:0] CW_MAX = M'(CW);

  logic [CW-1:0] placed;
  logic [M-1:0]  syn_c;
  logic [M-1:0]  s1;
  logic [K-1:0]  dat1;
  logic          v1;
  logic [K-1:0]  dout_c;

  always_comb begin : build_placed
    int di;
    int pi;
    di     = 0;
    pi     = 0;
    placed = '0;
    for (int j = 0; j < CW; j++) begin
      if (is_parity_pos(j)) begin
        placed[j] = cin[K+pi];
        pi++;
      end else begin
        placed[j] = cin[di];
        di++;
      end
    end
  end

  assign syn_c = M'(syndrome(MAX_CW'(placed), CW));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      s1   <= '0;
      dat1 <= '0;
    end else begin
      v1 <= cvld;
      if (cvld) begin
        s1   <= syn_c;
        dat1 <= cin[K-1:0];
      end
    end
  end

  // Only data positions matter for dout; a parity-position syndrome leaves data intact.
  always_comb begin : correct
    int di;
    di     = 0;
    dout_c = dat1;
    for (int j = 0; j < CW; j++) begin
      if (!is_parity_pos(j)) begin
        if (s1 == M'(j + 1)) dout_c[di] = ~dout_c[di];
        di++;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvld    <= 1'b0;
      dout    <= '0;
      corr    <= 1'b0;
      uncorr  <= 1'b0;
      err_pos <= '0;
    end else begin
      dvld <= v1;
      if (v1) begin
        dout    <= dout_c;
        corr    <= (s1 != '0) && (s1 <= CW_MAX);
        uncorr  <= (s1 > CW_MAX);
        err_pos <= s1;
      end
    end
  end

`ifdef HD_SYN_DEC_ERR_CNT_EN
  hd_sat_cnt #(.W(CNT_W)) u_corr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (dvld & corr),
    .cnt (corr_cnt)
  );

  hd_sat_cnt #(.W(CNT_W)) u_uncorr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (dvld & uncorr),
    .cnt (uncorr_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hd_syn_dec.sv
// Directed bench for hd_syn_dec: K=11 instance (CNT_W=2) plus a K=8 instance
// that exercises the out-of-range syndrome path.
module tb_hd_syn_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] cin;
  logic        cvld;
  logic        cnt_clr;
  logic [10:0] dout;
  logic        dvld, corr, uncorr;
  logic [3:0]  err_pos;
  logic [1:0]  corr_cnt, uncorr_cnt;

  logic [11:0] cin8;
  logic        cvld8;
  logic        cnt_clr8;
  logic [7:0]  dout8;
  logic        dvld8, corr8, uncorr8;
  logic [3:0]  err_pos8;
  logic [15:0] corr_cnt8, uncorr_cnt8;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hd_syn_dec #(.K(11), .M(4), .CNT_W(2)) u_dut (
    .clk (clk), .rst (rst), .cin (cin), .cvld (cvld),
    .dout (dout), .dvld (dvld), .corr (corr), .uncorr (uncorr),
    .err_pos (err_pos), .cnt_clr (cnt_clr),
    .corr_cnt (corr_cnt), .uncorr_cnt (uncorr_cnt)
  );

  hd_syn_dec #(.K(8), .M(4), .CNT_W(16)) u_dut8 (
    .clk (clk), .rst (rst), .cin (cin8), .cvld (cvld8),
    .dout (dout8), .dvld (dvld8), .corr (corr8), .uncorr (uncorr8),
    .err_pos (err_pos8), .cnt_clr (cnt_clr8),
    .corr_cnt (corr_cnt8), .uncorr_cnt (uncorr_cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [10:0] d, input logic co,
                         input logic uc, input logic [3:0] p);
    chk({tag, ".dvld"}, 32'(dvld), 32'd1);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".corr"}, 32'(corr), 32'(co));
    chk({tag, ".uncorr"}, 32'(uncorr), 32'(uc));
    chk({tag, ".err_pos"}, 32'(err_pos), 32'(p));
  endtask

  // One isolated word: no dvld after one cycle, result after two.
  task automatic send(input logic [14:0] c, input logic [10:0] d, input logic co,
                      input logic uc, input logic [3:0] p, input string tag);
    cin  = c;
    cvld = 1'b1;
    @(negedge clk);
    cvld = 1'b0;
    chk({tag, ".lat1"}, 32'(dvld), 32'd0);
    @(negedge clk);
    chk_res(tag, d, co, uc, p);
  endtask

  initial begin
    rst = 1'b0; cin = '0; cvld = 1'b0; cnt_clr = 1'b0;
    cin8 = '0; cvld8 = 1'b0; cnt_clr8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.dvld", 32'(dvld), 32'd0);
    chk("rst.dout", 32'(dout), 32'd0);
    chk("rst.corr", 32'(corr), 32'd0);
    chk("rst.uncorr", 32'(uncorr), 32'd0);
    chk("rst.err_pos", 32'(err_pos), 32'd0);
    chk("rst.corr_cnt", 32'(corr_cnt), 32'd0);
    chk("rst.uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    send(15'h0000, 11'h000, 1'b0, 1'b0, 4'd0,  "zero");
    send(15'h7FFF, 11'h7FF, 1'b0, 1'b0, 4'd0,  "ones");
    send(15'h7FFE, 11'h7FF, 1'b1, 1'b0, 4'd3,  "d0flip");
    send(15'h3FFF, 11'h7FF, 1'b1, 1'b0, 4'd8,  "p3flip");
    send(15'h1801, 11'h001, 1'b0, 1'b0, 4'd0,  "one");
    send(15'h1821, 11'h001, 1'b1, 1'b0, 4'd10, "d5flip");
    @(negedge clk);
    chk("hold.dvld", 32'(dvld), 32'd0);
    chk("hold.dout", 32'(dout), 32'h001);

    // Back-to-back stream, reset dropped while W2/W3 are in flight.
    cin = 15'h1821; cvld = 1'b1;
    @(negedge clk);
    cin = 15'h7FFF;
    chk("strm.idle", 32'(dvld), 32'd0);
    @(negedge clk);
    cin = 15'h7FFE;
    chk_res("strm.w0", 11'h001, 1'b1, 1'b0, 4'd10);
    @(negedge clk);
    cin = 15'h3FFF;
    chk_res("strm.w1", 11'h7FF, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst.dvld", 32'(dvld), 32'd0);
    chk("mid_rst.dout", 32'(dout), 32'd0);
    chk("mid_rst.corr", 32'(corr), 32'd0);
    chk("mid_rst.err_pos", 32'(err_pos), 32'd0);
    @(negedge clk);
    rst = 1'b1; cvld = 1'b0;
    @(negedge clk);
    chk("flush1.dvld", 32'(dvld), 32'd0);
    @(negedge clk);
    chk("flush2.dvld", 32'(dvld), 32'd0);
    send(15'h7FFE, 11'h7FF, 1'b1, 1'b0, 4'd3, "post_rst");

    // Statistics: saturation at 3 with CNT_W=2, then clear beats increment.
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr.corr_cnt", 32'(corr_cnt), 32'd0);
    for (int i = 0; i < 5; i++) send(15'h7FFE, 11'h7FF, 1'b1, 1'b0, 4'd3, "cnt_word");
    @(negedge clk);
`ifdef HD_SYN_DEC_ERR_CNT_EN
    chk("sat.corr_cnt", 32'(corr_cnt), 32'd3);
`else
    chk("sat.corr_cnt", 32'(corr_cnt), 32'd0);
`endif
    chk("sat.uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    cin = 15'h7FFE; cvld = 1'b1;
    @(negedge clk);
    cvld = 1'b0;
    @(negedge clk);
    chk("w6.corr", 32'(corr & dvld), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_wins.corr_cnt", 32'(corr_cnt), 32'd0);

    // K=8: syndrome 13 is beyond the 12-bit codeword, then a parity-bit error.
    cin8 = 12'h180; cvld8 = 1'b1;
    @(negedge clk);
    cin8 = 12'h701;
    @(negedge clk);
    cvld8 = 1'b0;
    chk("k8a.dvld", 32'(dvld8), 32'd1);
    chk("k8a.dout", 32'(dout8), 32'h80);
    chk("k8a.corr", 32'(corr8), 32'd0);
    chk("k8a.uncorr", 32'(uncorr8), 32'd1);
    chk("k8a.err_pos", 32'(err_pos8), 32'd13);
    @(negedge clk);
    chk("k8b.dvld", 32'(dvld8), 32'd1);
    chk("k8b.dout", 32'(dout8), 32'h01);
    chk("k8b.corr", 32'(corr8), 32'd1);
    chk("k8b.uncorr", 32'(uncorr8), 32'd0);
    chk("k8b.err_pos", 32'(err_pos8), 32'd4);
    @(negedge clk);
    chk("k8.dvld_end", 32'(dvld8), 32'd0);
`ifdef HD_SYN_DEC_ERR_CNT_EN
    chk("k8.uncorr_cnt", 32'(uncorr_cnt8), 32'd1);
    chk("k8.corr_cnt", 32'(corr_cnt8), 32'd1);
`else
    chk("k8.uncorr_cnt", 32'(uncorr_cnt8), 32'd0);
    chk("k8.corr_cnt", 32'(corr_cnt8), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hd_syn_dec.md
Name: hd_syn_dec

Overview:
- Pipelined Hamming single-error-correcting decoder; directly downstream of the Hamming encoder in the datapath.
- Consumes codewords in the encoder's packing and delivers corrected data words with error flags.
- Feeds the decoder-side data checker and optional error statistics.
- Fixed 2-cycle latency, valid-only flow: no backpressure, one codeword accepted per cycle.

Parameters:
- K, 11, data width in bits.
- M, 4, parity width in bits; must satisfy 2**M >= K+M+1.
- CNT_W, 16, width of the error statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- cin  input  K+M  received codeword, packed {parity[M-1:0], data[K-1:0]}.
- cvld  input  1  cin valid this cycle.
- dout  output  K  corrected data.
- dvld  output  1  dout and flags valid.
- corr  output  1  single error found and corrected (data or parity bit).
- uncorr  output  1  syndrome points outside the codeword; data passed uncorrected.
- err_pos  output  M  1-based error position (the syndrome); 0 when clean.
- cnt_clr  input  1  synchronous clear of the statistics counters (feature only).
- corr_cnt  output  CNT_W  count of corr events (feature only).
- uncorr_cnt  output  CNT_W  count of uncorr events (feature only).

Behaviour:
- Reset: clk and rst are fixed as one clock with asynchronous active-low reset. While rst=0, all registers and outputs are 0, including dvld, corr, uncorr, err_pos, dout and both counters.
- Placement: build placed[0..K+M-1].
  - Index j with (j+1) a power of two holds parity bit log2(j+1).
  - All other indices hold data bits 0..K-1 in ascending j.
- Syndrome: s[i] = XOR of placed[j] over all j where ((j+1) & 2**i) != 0.
- Stage 1 (cycle N+1): register s, data and parity fields, and cvld.
- Stage 2 (cycle N+2): register dvld, dout, corr, uncorr, err_pos.
  - s == 0: dout = data field; corr = 0, uncorr = 0, err_pos = 0.
  - 1 <= s <= K+M: flip placed[s-1], extract data; corr = 1, err_pos = s. A parity-only error still asserts corr; dout equals the received data field.
  - s > K+M (only possible when K+M < 2**M - 1): dout = data field unchanged; uncorr = 1, err_pos = s.
- Double errors are not detected; they miscorrect or raise uncorr depending on the syndrome value.
- When cvld=0, stage registers capture dvld=0. dout, corr, uncorr and err_pos hold their previous values but are meaningful only with dvld=1.
- Back-to-back cvld: one result per cycle, order preserved.
- Reset asserted mid-stream: in-flight words are discarded, with no dvld pulse after release. The first word after reset release appears 2 cycles after its cvld.

Optional Feature:
- Macro: HD_SYN_DEC_ERR_CNT_EN.
- Defined:
  - corr_cnt increments on each dvld&corr; uncorr_cnt increments on each dvld&uncorr.
  - Both counters saturate at all-ones.
  - cnt_clr=1 zeroes both on the next edge; clear wins over a simultaneous increment.
- Undefined: the counter logic is absent; corr_cnt and uncorr_cnt are tied to 0 and cnt_clr is ignored.

Decomposition:
- Shared package hd_pkg:
  - Functions/constants: placement map (is_parity_pos), CW_W = K+M, syndrome width M, syndrome function.
  - The encoder-side checker and this block share these so the codeword packing is single-sourced.
- Sub-module: hd_sat_cnt (saturating counter with sync clear, width CNT_W), instantiated twice under the macro.

Test Plan:
- K=11,M=4, cin=15'h0000, cvld=1 -> two cycles later dvld=1, dout=11'h000, corr=0, uncorr=0, err_pos=0.
- K=11,M=4, cin=15'h7FFF (clean encoding of 11'h7FF) -> dout=11'h7FF, corr=0, err_pos=0.
- K=11,M=4, cin=15'h7FFE (data bit 0 flipped) -> dout=11'h7FF, corr=1, err_pos=3. Then cin=15'h3FFF (parity bit 3 flipped) -> dout=11'h7FF, corr=1, err_pos=8.
- K=8,M=4, cin=12'h180 (positions 1 and 12 flipped from all-zero) -> syndrome 13, uncorr=1, dout=8'h80, err_pos=13.
- Back-to-back stream of 4 words then rst low for 1 cycle in the middle -> outputs match order, no dvld for flushed words, dvld resumes 2 cycles after first post-reset cvld.
- With HD_SYN_DEC_ERR_CNT_EN, CNT_W=2: 5 correctable words -> corr_cnt saturates at 3; cnt_clr coincident with a 6th corr -> corr_cnt=0.
